// File: rtl/keypad_player.sv
// Replays ASCII letters as multi-tap keypad presses followed by a submit press.
// Optional clear press before each letter: define KEYPAD_PLAYER_CLEAR_EN.
module keypad_player #(
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       end_req,
  output logic [7:0] cur_key,
  output logic       strobe,
  output logic       busy,
  output logic       err
);

  localparam int MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

  localparam logic [7:0] KEY_SUBMIT = 8'h18;
  localparam logic [7:0] KEY_END    = 8'h21;
`ifdef KEYPAD_PLAYER_CLEAR_EN
  localparam logic [7:0] KEY_CLEAR  = 8'h14;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_SUBMIT,
`ifdef KEYPAD_PLAYER_CLEAR_EN
    S_SGAP,
    S_CLR
`else
    S_SGAP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rem_q, rem_d;
  logic [7:0]    key_q, key_d;
  logic          end_q, end_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    cur_key_q, cur_key_d;
  logic          err_q, err_d;

  logic [7:0]    up;
  logic [7:0]    idx;
  logic          dec_ok;
  logic [7:0]    dec_key;
  logic [2:0]    dec_n;

  assign char_ready = (state_q == S_IDLE) && !end_req && !rst;
  assign busy       = (state_q != S_IDLE);
  assign strobe     = strobe_q;
  assign cur_key    = cur_key_q;
  assign err        = err_q;

  // Letter decode: fold to uppercase, then map alphabet index to key and tap count.
  always_comb begin
    up = char_in;
    if (char_in >= 8'h61 && char_in <= 8'h7A) begin
      up = char_in - 8'h20;
    end
    dec_ok  = (up >= 8'h41) && (up <= 8'h5A);
    idx     = up - 8'h41;
    dec_key = '0;
    dec_n   = '0;
    if (idx < 8'd3) begin
      dec_key = 8'h84;
      dec_n   = 3'(idx + 8'd1);
    end else if (idx < 8'd6) begin
      dec_key = 8'h82;
      dec_n   = 3'(idx - 8'd2);
    end else if (idx < 8'd9) begin
      dec_key = 8'h48;
      dec_n   = 3'(idx - 8'd5);
    end else if (idx < 8'd12) begin
      dec_key = 8'h44;
      dec_n   = 3'(idx - 8'd8);
    end else if (idx < 8'd15) begin
      dec_key = 8'h42;
      dec_n   = 3'(idx - 8'd11);
    end else if (idx < 8'd19) begin
      dec_key = 8'h28;
      dec_n   = 3'(idx - 8'd14);
    end else if (idx < 8'd22) begin
      dec_key = 8'h24;
      dec_n   = 3'(idx - 8'd18);
    end else begin
      dec_key = 8'h22;
      dec_n   = 3'(idx - 8'd21);
    end
  end

  // rem_q holds letter presses still to issue after the current strobe phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    key_d   = key_q;
    end_d   = end_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (end_req && !rst) begin
          state_d = S_PRESS;
          cnt_d   = '0;
          rem_d   = '0;
          key_d   = KEY_END;
          end_d   = 1'b1;
        end else if (char_valid && char_ready) begin
          if (dec_ok) begin
            cnt_d = '0;
            key_d = dec_key;
            end_d = 1'b0;
`ifdef KEYPAD_PLAYER_CLEAR_EN
            state_d = S_CLR;
            rem_d   = dec_n;
`else
            state_d = S_PRESS;
            rem_d   = dec_n - 3'd1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

`ifdef KEYPAD_PLAYER_CLEAR_EN
      S_CLR: begin
        if (cnt_q == S_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      S_PRESS: begin
        if (cnt_q == S_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == G_LAST) begin
          cnt_d = '0;
          if (rem_q != 3'd0) begin
            state_d = S_PRESS;
            rem_d   = rem_q - 3'd1;
          end else if (end_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SUBMIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SUBMIT: begin
        if (cnt_q == S_LAST) begin
          state_d = S_SGAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SGAP: begin
        if (cnt_q == G_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    strobe_d  = 1'b0;
    cur_key_d = '0;
    case (state_d)
      S_PRESS: begin
        strobe_d  = 1'b1;
        cur_key_d = key_d;
      end
      S_SUBMIT: begin
        strobe_d  = 1'b1;
        cur_key_d = KEY_SUBMIT;
      end
`ifdef KEYPAD_PLAYER_CLEAR_EN
      S_CLR: begin
        strobe_d  = 1'b1;
        cur_key_d = KEY_CLEAR;
      end
`endif
      default: begin
        strobe_d  = 1'b0;
        cur_key_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      key_q     <= '0;
      end_q     <= 1'b0;
      strobe_q  <= 1'b0;
      cur_key_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      key_q     <= key_d;
      end_q     <= end_d;
      strobe_q  <= strobe_d;
      cur_key_q <= cur_key_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/keypad_player.md
# keypad_player

Keypad event generator for the Wireless Hangman datapath. It accepts one ASCII letter per valid/ready handshake and replays it as the multi-tap press sequence the keypad FSM consumes: N strobed presses of the letter's key, then one press of the submit-letter key. It is used for remote-player injection (characters from the radio link) and for self-test, and drives the same `cur_key`/`strobe` interface as the physical keypad scanner.

## Interface
- `STROBE_CYCLES`, default 1: cycles `strobe` stays high per press (≥1).
- `GAP_CYCLES`, default 4: idle cycles with `strobe` low after every press (≥1).

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `char_in`  in  8  ASCII character.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  the block can accept a character. A transfer occurs when `char_valid && char_ready`.
- `end_req`  in  1  request to emit a single game-end key press.
- `cur_key`  out  8  keypad code as {row[3:0], col[3:0]}, one-hot.
- `strobe`  out  1  press-valid qualifier for `cur_key`.
- `busy`  out  1  a sequence is in progress.
- `err`  out  1  one-cycle pulse when a non-letter character is accepted.

## Operation
- Key codes:
  - `2`=8'h84, `3`=8'h82, `4`=8'h48, `5`=8'h44, `6`=8'h42, `7`=8'h28, `8`=8'h24, `9`=8'h22.
  - Submit-letter `*`=8'h18, clear `0`=8'h14, game-end `C`=8'h21.
- Letter groups:
  - A–C→2, D–F→3, G–I→4, J–L→5, M–O→6, P–S→7, T–V→8, W–Z→9.
  - Press count equals the letter's position in its group (1..4). For example, S=4 presses of 7 and Z=4 presses of 9.
- Case folding: 0x61–0x7A are folded to uppercase before decoding.
- Invalid characters: anything outside 0x41–0x5A and 0x61–0x7A is still accepted (handshake completes). The block pulses `err` and emits no presses.
- States:
  - IDLE: `char_ready=1`.
  - CLR (only when configured in; see Configuration).
  - PRESS: `strobe=1` for STROBE_CYCLES.
  - GAP: `strobe=0` for GAP_CYCLES.
  - SUBMIT: `strobe=1` with 8'h18.
  - SGAP: `strobe=0` for GAP_CYCLES, then return to IDLE.
- Transitions:
  - IDLE→PRESS on a valid letter.
  - PRESS→GAP.
  - GAP→PRESS while presses remain; GAP→SUBMIT after the last letter press.
  - SUBMIT→SGAP.
  - SGAP→IDLE.
- Game-end request: `end_req` in IDLE emits one 8'h21 press plus its gap, with no submit, then returns to IDLE.
- `end_req` has priority: `char_ready = (state==IDLE) && !end_req && !rst`. A simultaneous character therefore waits.
- Registered outputs: `cur_key` equals the active code while `strobe=1` and 8'h00 otherwise.
- Decode latch: the key code and press count are latched at the handshake. `char_in` may change afterwards.
- Counters: the press counter is 3 bits and the cycle counter is sized by $clog2(max(STROBE_CYCLES, GAP_CYCLES)+1).

## Timing
- Reset values: `strobe=0`, `cur_key=8'h00`, `busy=0`, `err=0`, state IDLE. `char_ready` is 0 while `rst` is high and 1 on the first cycle after release.
- Handshake at edge t:
  - `strobe` first rises at t+1.
  - The k-th letter press starts at t+1+(k−1)(S+G).
  - Submit starts at t+1+n(S+G).
  - `char_ready` returns high at t+1+(n+1)(S+G), where S=STROBE_CYCLES and G=GAP_CYCLES.
- `busy` is high from t+1 until `char_ready` reasserts.
- `err` is high only at t+1, with `char_ready` staying high.
- Back-to-back characters with identical keys: always separated by a submit press. This resets the multi-tap chain downstream, so no extra gap is inserted.
- `rst` mid-sequence: at the next edge `strobe` and `cur_key` drop to 0 and the state returns to IDLE. The partial letter is abandoned with no submit emitted.
- `char_valid` dropping while `char_ready=0` has no effect; there is no buffering beyond the one latched character.

## Configuration
- `KEYPAD_PLAYER_CLEAR_EN`:
  - Defined: every letter sequence starts with one clear press (8'h14, S+G cycles), so letter presses shift by S+G and `char_ready` returns at t+1+(n+2)(S+G). Invalid characters and `end_req` never emit a clear press.
  - Undefined: the CLR state does not exist and timing is exactly as above.

## Test plan
All scenarios use S=1, G=4, clear undefined unless stated.
- 'C' (0x43) at t → 8'h84 strobes at t+1, t+6, t+11; 8'h18 at t+16; `char_ready` high at t+21; `busy` high for t+1..t+20.
- 'z' (0x7A) → four 8'h22 strobes at t+1/6/11/16, 8'h18 at t+21, ready at t+26. 'p' (0x70) → one 8'h28 strobe, 8'h18 at t+6, ready at t+11.
- '5' (0x35) → `err`=1 at t+1 only, no strobe, `char_ready` stays 1.
- `end_req` and `char_valid` (with 'A') both high at t → 8'h21 strobe at t+1; 'A' is not accepted until t+6; its 8'h84 press follows at t+7.
- `rst` asserted at t+7 during 'S' → `strobe`=0 and `cur_key`=0 at t+8, no 8'h18 emitted, `char_ready` high after release.
- With `KEYPAD_PLAYER_CLEAR_EN`, 'A' → 8'h14 at t+1, 8'h84 at t+6, 8'h18 at t+11, ready at t+16.
